// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared fetch-stage constants and FSM state type
package if_fetch_unit_pkg;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int EXC_W = 8;
  localparam int ADEL_BIT = 0;
  localparam logic [EXC_W-1:0] EXC_ADEL = EXC_W'(1) << ADEL_BIT;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage driving an SRAM-style bus and the IF/ID result register
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             id_is_branch,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             exc_flush,
  input  logic [31:0]      exc_pc,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      instruction,
  output logic             is_delayslot,
  output logic [EXC_W-1:0] fetch_exc,
  output logic             fetch_busy
);
  fetch_state_e state;
  logic [31:0] pc, br_tgt, res_instr, res_pc4, next_pc, fetch_pc;
  logic [EXC_W-1:0] res_exc;
  logic res_valid, pend_br, discard, consume, done;
  always_comb begin
    consume = res_valid & ~stall;
    next_pc = br_taken ? br_target : pend_br ? br_tgt : pc + 32'd4;
    fetch_pc = consume ? next_pc : pc;
    done = inst_data_ok & ((state == WAIT) | ((state == REQ) & inst_addr_ok));
  end
  // inst_addr is its own register so a flush cannot disturb a request awaiting addr_ok
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      inst_addr <= RESET_PC;
      br_tgt <= '0;
      pend_br <= 1'b0;
      discard <= 1'b0;
      res_valid <= 1'b0;
      res_instr <= '0;
      res_pc4 <= '0;
      res_exc <= '0;
    end else if (exc_flush) begin
      pc <= exc_pc;
      res_valid <= 1'b0;
      pend_br <= 1'b0;
      discard <= (state != IDLE) & ~done;
      state <= done ? IDLE : (state == REQ && inst_addr_ok) ? WAIT : state;
    end else begin
      if (br_taken & ~consume) begin
        br_tgt <= br_target;
        pend_br <= 1'b1;
      end else if (consume) pend_br <= 1'b0;
      if (state == IDLE && (!res_valid || consume)) begin
        pc <= fetch_pc;
        if (fetch_pc[1:0] != 2'b00) begin
          res_valid <= 1'b1;
          res_instr <= '0;
          res_pc4 <= fetch_pc + 32'd4;
          res_exc <= EXC_ADEL;
        end else begin
          res_valid <= 1'b0;
          inst_addr <= fetch_pc;
          state <= REQ;
        end
      end else if (done) begin
        state <= IDLE;
        discard <= 1'b0;
        res_valid <= ~discard;
        res_instr <= inst_rdata;
        res_pc4 <= inst_addr + 32'd4;
        res_exc <= '0;
      end else if (state == REQ && inst_addr_ok) state <= WAIT;
    end
  end
  assign inst_req = state == REQ;
  assign instruction = res_valid ? res_instr : '0;
  assign pc_plus4 = res_valid ? res_pc4 : '0;
  assign fetch_exc = res_valid ? res_exc : '0;
  assign is_delayslot = res_valid & id_is_branch;
  assign fetch_busy = ~res_valid;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scoreboard bench for the instruction-fetch stage
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [EXC_W-1:0] exc;
    logic ds;
  } res_t;
  logic clk = 0, rst = 1, stall = 1, id_is_branch = 1, br_taken = 0, exc_flush = 0;
  logic [31:0] br_target = '0, exc_pc = '0;
  logic inst_req, inst_addr_ok, inst_data_ok, is_delayslot, fetch_busy;
  logic [31:0] inst_addr, inst_rdata, pc_plus4, instruction;
  logic [EXC_W-1:0] fetch_exc;
  logic [31:0] exp_addr[$];
  res_t exp_res[$];
  res_t mon_e;
  int n_chk = 0, n_pass = 0, n_fail = 0, n_cons = 0, n_acc = 0;
  int addr_delay = 0, data_delay = 0, req_age = 0, out_cnt = 0;
  logic out_v = 0;
  logic [31:0] out_addr = '0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .id_is_branch(id_is_branch),
    .br_taken(br_taken), .br_target(br_target), .exc_flush(exc_flush), .exc_pc(exc_pc),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .pc_plus4(pc_plus4),
    .instruction(instruction), .is_delayslot(is_delayslot), .fetch_exc(fetch_exc),
    .fetch_busy(fetch_busy)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == RESET_PC ? 32'h2408_0001 : a ^ 32'h1357_9BDF;
  endfunction

  // Bus model: addr_ok after addr_delay cycles of req, data after data_delay (0 = same cycle)
  assign inst_addr_ok = inst_req && req_age >= addr_delay && !out_v;
  assign inst_data_ok = data_delay == 0 ? inst_addr_ok : (out_v && out_cnt == 0);
  assign inst_rdata = mem(data_delay == 0 ? inst_addr : out_addr);
  always @(posedge clk) begin
    req_age <= (inst_req && !inst_addr_ok) ? req_age + 1 : 0;
    if (inst_addr_ok && data_delay > 0) begin
      out_v <= 1'b1;
      out_addr <= inst_addr;
      out_cnt <= data_delay - 1;
    end else if (out_v) begin
      if (out_cnt == 0) out_v <= 1'b0;
      else out_cnt <= out_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (inst_req && inst_addr_ok) begin
      n_acc++;
      chk("addr_q_nonempty", exp_addr.size() != 0, 1);
      if (exp_addr.size() != 0) chk("inst_addr", inst_addr, exp_addr.pop_front());
    end
    if (!fetch_busy && !stall) begin
      n_cons++;
      chk("res_q_nonempty", exp_res.size() != 0, 1);
      if (exp_res.size() != 0) begin
        mon_e = exp_res.pop_front();
        chk("res_instr", instruction, mon_e.instr);
        chk("res_pc4", pc_plus4, mon_e.pc4);
        chk("res_exc", fetch_exc, mon_e.exc);
        chk("res_ds", is_delayslot, mon_e.ds);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic ds);
    exp_addr.push_back(a);
    exp_res.push_back('{instr: mem(a), pc4: a + 32'd4, exc: '0, ds: ds});
  endtask

  task automatic flush(input logic [31:0] a);
    exc_pc = a;
    exc_flush = 1;
    tick();
    exc_flush = 0;
  endtask

  task automatic wait_cons(input int n);
    for (int t = 0; t < 200 && n_cons < n; t++) tick();
    chk("wait_cons", n_cons >= n, 1);
  endtask

  task automatic wait_acc(input int n);
    for (int t = 0; t < 200 && n_acc < n; t++) tick();
    chk("wait_acc", n_acc >= n, 1);
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 200 && fetch_busy; t++) tick();
    chk("wait_valid", fetch_busy, 0);
  endtask

  task automatic wait_req();
    for (int t = 0; t < 200 && !inst_req; t++) tick();
    chk("wait_req", inst_req, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_req", inst_req, 0);
    chk("rst_busy", fetch_busy, 1);
    chk("rst_pc4", pc_plus4, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_exc", fetch_exc, 0);
    chk("rst_ds", is_delayslot, 0);
    chk("rst_addr", inst_addr, RESET_PC);
    id_is_branch = 0;
    push_fetch(RESET_PC, 0);
    rst = 0;
    wait_valid();
    chk("first_pc4", pc_plus4, 32'hBFC0_0004);
    chk("first_instr", instruction, 32'h2408_0001);
    chk("first_exc", fetch_exc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {inst_req, pc_plus4, instruction}, {1'b0, 32'hBFC0_0004, 32'h2408_0001});
    end
    data_delay = 2;
    push_fetch(32'hBFC0_0004, 0);
    push_fetch(32'hBFC0_0008, 1);
    push_fetch(32'h8000_0100, 0);
    exp_addr.push_back(32'h8000_0104);
    stall = 0;
    wait_cons(2);
    id_is_branch = 1;
    wait_acc(3);
    br_target = 32'h8000_0100;
    br_taken = 1;
    tick();
    br_taken = 0;
    wait_cons(3);
    id_is_branch = 0;
    wait_cons(4);
    wait_acc(5);
    exp_addr.push_back(32'hBFC0_0380);
    stall = 1;
    flush(32'hBFC0_0380);
    wait_valid();
    chk("flush_pc4", pc_plus4, 32'hBFC0_0384);
    chk("flush_instr", instruction, mem(32'hBFC0_0380));
    chk("flush_consumed", n_cons, 4);
    flush(32'h8000_0102);
    wait_valid();
    chk("adel_instr", instruction, 0);
    chk("adel_exc", fetch_exc, 8'h01);
    chk("adel_pc4", pc_plus4, 32'h8000_0106);
    chk("adel_req", inst_req, 0);
    addr_delay = 4;
    data_delay = 1;
    exp_addr.push_back(32'h0000_1000);
    exp_addr.push_back(32'h0000_2000);
    flush(32'h0000_1000);
    wait_req();
    chk("hold_c0", {inst_req, inst_addr}, {1'b1, 32'h0000_1000});
    tick();
    chk("hold_c1", {inst_req, inst_addr}, {1'b1, 32'h0000_1000});
    flush(32'h0000_2000);
    chk("hold_c2", {inst_req, inst_addr}, {1'b1, 32'h0000_1000});
    tick();
    chk("hold_c3", {inst_req, inst_addr}, {1'b1, 32'h0000_1000});
    wait_valid();
    chk("redirect_instr", instruction, mem(32'h0000_2000));
    chk("redirect_pc4", pc_plus4, 32'h0000_2004);
    addr_delay = 0;
    data_delay = 0;
    push_fetch(32'hFFFF_FFFC, 0);
    exp_addr.push_back(32'h0000_0000);
    flush(32'hFFFF_FFFC);
    wait_valid();
    chk("wrap_pc4", pc_plus4, 32'h0000_0000);
    chk("wrap_instr", instruction, mem(32'hFFFF_FFFC));
    stall = 0;
    wait_cons(5);
    stall = 1;
    wait_valid();
    chk("zero_pc4", pc_plus4, 32'h0000_0004);
    chk("zero_instr", instruction, mem(32'h0000_0000));
    data_delay = 3;
    exp_addr.push_back(32'h0000_3000);
    exp_addr.push_back(RESET_PC);
    flush(32'h0000_3000);
    wait_acc(n_acc + 1);
    rst = 1;
    #1;
    chk("midrst_busy", fetch_busy, 1);
    chk("midrst_req", inst_req, 0);
    tick();
    tick();
    rst = 0;
    wait_valid();
    chk("postrst_instr", instruction, 32'h2408_0001);
    chk("postrst_pc4", pc_plus4, 32'hBFC0_0004);
    chk("addr_q_drained", exp_addr.size(), 0);
    chk("res_q_drained", exp_res.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
